// File: rtl/axis_bcd_converter.sv
// axis_bcd_converter: converts CHANNELS signed fixed-point samples
// (RESOLUTION LSBs per unit) into packed BCD integer/fraction digits.
// A single bit-serial restoring divider is shared by the integer split,
// the integer digit extraction and the fractional digit extraction.
// Optional feature: define AXIS_BCD_SIGN_EN to convert negative samples
// by magnitude and report them on Sign_o; otherwise negatives clamp to 0.
module axis_bcd_converter #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RESOLUTION  = 256,
  parameter int unsigned INT_DIGITS  = 1,
  parameter int unsigned FRAC_DIGITS = 2
) (
  input  logic                                           Clk_i,
  input  logic                                           Reset_i,
  input  logic                                           Data_Available_i,
  input  logic [CHANNELS*DATA_W-1:0]                     Data_i,
  output logic                                           Busy_o,
  output logic                                           Data_Available_o,
  output logic [CHANNELS*(INT_DIGITS+FRAC_DIGITS)*4-1:0] Data_o,
  output logic [CHANNELS-1:0]                            Overflow_o,
  output logic [CHANNELS-1:0]                            Sign_o
);

  localparam int unsigned NDIG    = INT_DIGITS + FRAC_DIGITS;
  localparam int unsigned FIELD_W = NDIG * 4;
  localparam int unsigned MAG_W   = DATA_W + 1;
  // 10*r < 10*RESOLUTION < 2^(DATA_W+3), so DATA_W+3 bits hold every dividend.
  localparam int unsigned DW      = DATA_W + 3;
  localparam int unsigned CNT_W   = $clog2(DW + 2);
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DIG_W   = $clog2(NDIG) + 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]   INT_LIMIT = pow10(INT_DIGITS);
  localparam logic [DW-1:0] RES_DEN   = DW'(RESOLUTION);
  localparam logic [DW-1:0] TEN_DEN   = DW'(10);

  typedef enum logic [2:0] {
    IDLE, LOAD, DIV_INT, BCD_INT, BCD_FRAC, NEXT, DONE
  } state_t;

  state_t                       state, state_nxt;
  logic [CHANNELS*DATA_W-1:0]   snap;
  logic [CH_W-1:0]              ch_idx;
  logic [CNT_W-1:0]             cnt;
  logic [DIG_W-1:0]             dig;
  logic [MAG_W-1:0]             q;
  logic [DATA_W-1:0]            r;
  logic [FIELD_W-1:0]           field;
  logic                         ovf_cur;
  logic [CHANNELS*FIELD_W-1:0]  res_data;
  logic [CHANNELS-1:0]          res_ovf;
  logic                         busy_q;
  logic [DW-1:0]                div_quo, div_rem, div_den;

  // combinational helpers
  logic [DATA_W-1:0] cur_x;
  logic [MAG_W-1:0]  mag_c;
  logic [DW:0]       rem_sh, rem_diff;
  logic              take;
  logic [DW-1:0]     rem_nxt, quo_nxt;
  logic [DW-1:0]     r_x10;
  logic              int_ovf, step_setup, step_done, last_ch;
  logic              arith_state;
  int unsigned       nib_int, nib_frac;
  logic              div_unused;

`ifdef AXIS_BCD_SIGN_EN
  logic                sign_cur;
  logic [CHANNELS-1:0] res_sign;
`endif

  assign Busy_o     = busy_q;
  assign div_unused = rem_diff[DW];

  // channel selection, magnitude, divider step and digit bookkeeping
  always_comb begin
    cur_x = snap[ch_idx*DATA_W +: DATA_W];
`ifdef AXIS_BCD_SIGN_EN
    mag_c = cur_x[DATA_W-1] ? (MAG_W'(0) - {cur_x[DATA_W-1], cur_x}) : {1'b0, cur_x};
`else
    mag_c = cur_x[DATA_W-1] ? '0 : {1'b0, cur_x};
`endif
    rem_sh      = {div_rem, div_quo[DW-1]};
    rem_diff    = rem_sh - {1'b0, div_den};
    take        = (rem_sh >= {1'b0, div_den});
    rem_nxt     = take ? rem_diff[DW-1:0] : rem_sh[DW-1:0];
    quo_nxt     = {div_quo[DW-2:0], take};
    r_x10       = {r, 3'b000} + {2'b00, r, 1'b0};
    int_ovf     = (64'(q) >= INT_LIMIT);
    step_setup  = (cnt == '0);
    step_done   = (cnt == CNT_W'(DW + 1));
    last_ch     = (ch_idx == CH_W'(CHANNELS - 1));
    arith_state = (state == DIV_INT) || (state == BCD_INT) || (state == BCD_FRAC);
    nib_int     = (FRAC_DIGITS + 32'(dig)) * 4;
    nib_frac    = (FRAC_DIGITS - 1 - 32'(dig)) * 4;
  end

  // state register
  always_ff @(posedge Clk_i) begin
    if (Reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Data_Available_i) state_nxt = LOAD;
      LOAD:     state_nxt = DIV_INT;
      DIV_INT:  if (step_done) state_nxt = BCD_INT;
      BCD_INT: begin
        if (step_setup && dig == '0 && int_ovf)
          state_nxt = NEXT;
        else if (step_done && dig == DIG_W'(INT_DIGITS - 1))
          state_nxt = (FRAC_DIGITS == 0) ? NEXT : BCD_FRAC;
      end
      BCD_FRAC: if (step_done && dig == DIG_W'(FRAC_DIGITS - 1)) state_nxt = NEXT;
      NEXT:     state_nxt = last_ch ? DONE : LOAD;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // datapath: snapshot, shared divider, digit assembly and result publishing
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      snap             <= '0;
      ch_idx           <= '0;
      cnt              <= '0;
      dig              <= '0;
      q                <= '0;
      r                <= '0;
      field            <= '0;
      ovf_cur          <= 1'b0;
      res_data         <= '0;
      res_ovf          <= '0;
      busy_q           <= 1'b0;
      div_quo          <= '0;
      div_rem          <= '0;
      div_den          <= '0;
      Data_Available_o <= 1'b0;
      Data_o           <= '0;
      Overflow_o       <= '0;
`ifdef AXIS_BCD_SIGN_EN
      sign_cur         <= 1'b0;
      res_sign         <= '0;
      Sign_o           <= '0;
`endif
    end else begin
      Data_Available_o <= 1'b0;
      if (arith_state && !step_done && state_nxt == state) cnt <= cnt + 1'b1;
      else                                                 cnt <= '0;

      case (state)
        IDLE: begin
          if (Data_Available_i) begin
            snap   <= Data_i;
            busy_q <= 1'b1;
            ch_idx <= '0;
          end
        end
        LOAD: begin
          q       <= mag_c;
          field   <= '0;
          ovf_cur <= 1'b0;
          dig     <= '0;
`ifdef AXIS_BCD_SIGN_EN
          sign_cur <= cur_x[DATA_W-1];
`endif
        end
        DIV_INT: begin
          if (step_setup) begin
            div_quo <= DW'(q);
            div_rem <= '0;
            div_den <= RES_DEN;
          end else if (step_done) begin
            q <= div_quo[MAG_W-1:0];
            r <= div_rem[DATA_W-1:0];
          end else begin
            div_quo <= quo_nxt;
            div_rem <= rem_nxt;
          end
        end
        BCD_INT: begin
          if (step_setup) begin
            if (dig == '0 && int_ovf) begin
              field   <= {NDIG{4'h9}};
              ovf_cur <= 1'b1;
            end else begin
              div_quo <= DW'(q);
              div_rem <= '0;
              div_den <= TEN_DEN;
            end
          end else if (step_done) begin
            field[nib_int +: 4] <= div_rem[3:0];
            q                   <= div_quo[MAG_W-1:0];
            dig <= (dig == DIG_W'(INT_DIGITS - 1)) ? '0 : dig + 1'b1;
          end else begin
            div_quo <= quo_nxt;
            div_rem <= rem_nxt;
          end
        end
        BCD_FRAC: begin
          if (step_setup) begin
            div_quo <= r_x10;
            div_rem <= '0;
            div_den <= RES_DEN;
          end else if (step_done) begin
            field[nib_frac +: 4] <= div_quo[3:0];
            r                    <= div_rem[DATA_W-1:0];
            dig                  <= dig + 1'b1;
          end else begin
            div_quo <= quo_nxt;
            div_rem <= rem_nxt;
          end
        end
        NEXT: begin
          res_data[ch_idx*FIELD_W +: FIELD_W] <= field;
          res_ovf[ch_idx]                     <= ovf_cur;
`ifdef AXIS_BCD_SIGN_EN
          res_sign[ch_idx]                    <= sign_cur;
`endif
          if (!last_ch) ch_idx <= ch_idx + 1'b1;
        end
        DONE: begin
          Data_o           <= res_data;
          Overflow_o       <= res_ovf;
`ifdef AXIS_BCD_SIGN_EN
          Sign_o           <= res_sign;
`endif
          Data_Available_o <= 1'b1;
          busy_q           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef AXIS_BCD_SIGN_EN
  assign Sign_o = '0;
`endif

endmodule

// File: tb/tb_axis_bcd_converter.sv
// Testbench for axis_bcd_converter: default configuration plus a
// CHANNELS=1 / DATA_W=12 / RESOLUTION=100 / 2.1-digit instance.
module tb_axis_bcd_converter;

`ifdef AXIS_BCD_SIGN_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  localparam int BOUND0 = 3 * (3 + 4 * (16 + 5)) + 2;
  localparam int BOUND1 = 1 * (3 + 4 * (12 + 5)) + 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dav;
  logic [47:0] din;
  logic        busy, dav_o;
  logic [35:0] dout;
  logic [2:0]  ovf, sgn;

  logic        dav1;
  logic [11:0] din1;
  logic        busy1, dav_o1;
  logic [11:0] dout1;
  logic        ovf1, sgn1;

  axis_bcd_converter u_dut (
    .Clk_i(clk), .Reset_i(rst), .Data_Available_i(dav), .Data_i(din),
    .Busy_o(busy), .Data_Available_o(dav_o), .Data_o(dout),
    .Overflow_o(ovf), .Sign_o(sgn)
  );

  axis_bcd_converter #(
    .CHANNELS(1), .DATA_W(12), .RESOLUTION(100), .INT_DIGITS(2), .FRAC_DIGITS(1)
  ) u_dut1 (
    .Clk_i(clk), .Reset_i(rst), .Data_Available_i(dav1), .Data_i(din1),
    .Busy_o(busy1), .Data_Available_o(dav_o1), .Data_o(dout1),
    .Overflow_o(ovf1), .Sign_o(sgn1)
  );

  typedef struct {
    logic [47:0] din;
    logic [35:0] dout;
    logic [2:0]  ovf;
    logic [2:0]  sgn;
  } vec_t;

  typedef struct {
    logic [11:0] din;
    logic [11:0] dout;
    logic        ovf;
    logic        sgn;
  } vec1_t;

  vec_t  vecs[5];
  vec1_t vecs1[4];
  vec_t  exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every done pulse pops one expected record
  always @(negedge clk) begin
    vec_t e;
    if (dav_o === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got a done pulse, expected none");
      end else begin
        e = exp_q.pop_front();
        check("data", 64'(dout), 64'(e.dout));
        check("overflow", 64'(ovf), 64'(e.ovf));
        check("sign", 64'(sgn), 64'(e.sgn));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic start_req(input vec_t v);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_before_request", 64'(busy), 64'd0);
    exp_q.push_back(v);
    dav = 1'b1;
    din = v.din;
    @(negedge clk);
    dav = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (dav_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("latency_within_bound", 64'(n >= 1 && n <= BOUND0), 64'd1);
  endtask

  initial begin
    int n, d0;
    vec_t b;

    vecs[0] = '{din: {16'd64, 16'd0, 16'd384}, dout: 36'h025_000_150, ovf: 3'b000, sgn: 3'b000};
    vecs[1] = '{din: {16'd32767, 16'd2600, 16'(-128)},
                dout: SE ? 36'h999_999_050 : 36'h999_999_000, ovf: 3'b110,
                sgn: SE ? 3'b001 : 3'b000};
    vecs[2] = '{din: {16'd255, 16'h8000, 16'd0},
                dout: SE ? 36'h099_999_000 : 36'h099_000_000,
                ovf: SE ? 3'b010 : 3'b000, sgn: SE ? 3'b010 : 3'b000};
    vecs[3] = '{din: {16'hFFFF, 16'd2560, 16'd2559}, dout: 36'h000_999_999, ovf: 3'b010,
                sgn: SE ? 3'b100 : 3'b000};
    vecs[4] = '{din: {16'd2304, 16'd128, 16'd1}, dout: 36'h900_050_000, ovf: 3'b000, sgn: 3'b000};

    vecs1[0] = '{din: 12'd1234, dout: 12'h123, ovf: 1'b0, sgn: 1'b0};
    vecs1[1] = '{din: 12'd999,  dout: 12'h099, ovf: 1'b0, sgn: 1'b0};
    vecs1[2] = '{din: 12'd2047, dout: 12'h204, ovf: 1'b0, sgn: 1'b0};
    vecs1[3] = '{din: 12'(-1234), dout: SE ? 12'h123 : 12'h000, ovf: 1'b0, sgn: SE};

    rst = 1'b1; dav = 1'b0; din = '0; dav1 = 1'b0; din1 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(dav_o), 64'd0);
    check("reset_data", 64'(dout), 64'd0);
    check("reset_overflow", 64'(ovf), 64'd0);
    check("reset_sign", 64'(sgn), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // table vectors, each new request issued in the done-pulse cycle
    for (int i = 0; i < 5; i++) begin
      start_req(vecs[i]);
      check("busy_after_capture", 64'(busy), 64'd1);
      wait_done(n);
    end
    repeat (10) @(negedge clk);
    check("hold_data", 64'(dout), 64'(vecs[4].dout));
    check("hold_overflow", 64'(ovf), 64'(vecs[4].ovf));

    // second request and new data while busy are ignored
    d0 = done_cnt;
    start_req(vecs[1]);
    repeat (20) @(negedge clk);
    b = vecs[0];
    dav = 1'b1; din = b.din;
    @(negedge clk);
    dav = 1'b0;
    wait_done(n);
    repeat (300) @(negedge clk);
    check("single_done_pulse", 64'(done_cnt - d0), 64'd1);

    // reset mid-conversion aborts without a pulse
    start_req(vecs[0]);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_data", 64'(dout), 64'd0);
    check("abort_overflow", 64'(ovf), 64'd0);
    check("abort_sign", 64'(sgn), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    start_req(vecs[4]);
    wait_done(n);
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // single-channel, 2.1-digit instance
    for (int i = 0; i < 4; i++) begin
      dav1 = 1'b1; din1 = vecs1[i].din;
      @(negedge clk);
      dav1 = 1'b0;
      n = 0;
      while (dav_o1 !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("cfg1_latency", 64'(n >= 1 && n <= BOUND1), 64'd1);
      check("cfg1_data", 64'(dout1), 64'(vecs1[i].dout));
      check("cfg1_overflow", 64'(ovf1), 64'(vecs1[i].ovf));
      check("cfg1_sign", 64'(sgn1), 64'(vecs1[i].sgn));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_bcd_converter.md
AXIS_BCD_CONVERTER -- requirements
Module: axis_bcd_converter

Interface
REQ-001 SHALL provide parameter CHANNELS, default 3: number of signed input samples converted per request.
REQ-002 SHALL provide parameter DATA_W, default 16: width of each two's-complement input sample.
REQ-003 SHALL provide parameter RESOLUTION, default 256: LSBs per unit; legal range 2 to 2^(DATA_W-1)-1.
REQ-004 SHALL provide parameter INT_DIGITS, default 1: number of BCD integer digits per channel.
REQ-005 SHALL provide parameter FRAC_DIGITS, default 2: number of BCD fractional digits per channel.
REQ-006 SHALL provide port Clk_i  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL provide port Reset_i  input  1  reset, synchronous and active-high.
REQ-008 SHALL provide port Data_Available_i  input  1  conversion request; new samples are valid in the same cycle.
REQ-009 SHALL provide port Data_i  input  CHANNELS*DATA_W  samples, channel 0 in the LSBs.
REQ-010 SHALL provide port Busy_o  output  1  high from capture until the done pulse.
REQ-011 SHALL provide port Data_Available_o  output  1  one-cycle done pulse.
REQ-012 SHALL provide port Data_o  output  CHANNELS*(INT_DIGITS+FRAC_DIGITS)*4  BCD result, channel 0 in the LSBs.
REQ-013 SHALL provide port Overflow_o  output  CHANNELS  per-channel integer saturation flag.
REQ-014 SHALL provide port Sign_o  output  CHANNELS  per-channel negative flag.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, DIV_INT, BCD_INT, BCD_FRAC, NEXT and DONE.
REQ-016 SHALL, in IDLE when Data_Available_i=1, capture all of Data_i into an internal snapshot, assert Busy_o on the next cycle, and enter LOAD.
REQ-017 SHALL ignore Data_Available_i while Busy_o=1; later changes on Data_i SHALL NOT affect the current conversion.
REQ-018 SHALL, in LOAD, form the magnitude |x| on DATA_W+1 bits, so that -2^(DATA_W-1) converts correctly, and select channels in ascending order.
REQ-019 SHALL, in DIV_INT, compute q = |x| div RESOLUTION and r = |x| mod RESOLUTION using an internal bit-serial restoring divider; no vendor divider IP.
REQ-020 SHALL, in BCD_INT, emit INT_DIGITS digits of q by repeated mod/div 10, least significant digit first.
REQ-021 SHALL, in BCD_INT when q >= 10^INT_DIGITS, set all integer and fractional digits of that channel to 9 and set Overflow_o[ch]=1.
REQ-022 SHALL, in BCD_FRAC, emit FRAC_DIGITS digits, most significant first, each as digit = (10*r) div RESOLUTION with r updated to (10*r) mod RESOLUTION, truncating rather than rounding.
REQ-023 SHALL pack each channel field with the most significant integer digit in the highest nibble and the last fractional digit in the lowest nibble.
REQ-024 SHALL, in NEXT, advance to LOAD for the next channel, or go to DONE after channel CHANNELS-1.
REQ-025 SHALL, in DONE, update Data_o, Overflow_o and Sign_o atomically, pulse Data_Available_o for exactly one cycle, deassert Busy_o in the same cycle, and return to IDLE.
REQ-026 SHALL hold Data_o, Overflow_o and Sign_o stable between done pulses.
REQ-027 SHALL complete a request within CHANNELS*(3+(1+INT_DIGITS+FRAC_DIGITS)*(DATA_W+5))+2 cycles from the capture edge to the done pulse.
REQ-028 SHALL accept a new request in the cycle after the done pulse.

Reset
REQ-029 SHALL, while Reset_i=1 at a rising edge, force IDLE, clear the snapshot, and drive Busy_o, Data_Available_o, Data_o, Overflow_o and Sign_o to 0.
REQ-030 SHALL, on reset during a conversion, abort the conversion without producing a Data_Available_o pulse and discard any partial results.

Configuration
REQ-031 SHALL, with macro AXIS_BCD_SIGN_EN defined, convert |x| for negative samples and set Sign_o[ch]=1.
REQ-032 SHALL, without AXIS_BCD_SIGN_EN, clamp negative samples to 0 (all-zero digits, Overflow_o[ch]=0) and tie Sign_o to 0; the port SHALL remain present.

Verification (defaults unless noted)
REQ-033 SHALL cover: samples {384, 0, 64} -> Data_o = 0x025_000_150, Overflow_o = 0, done pulse within the REQ-027 bound.
REQ-034 SHALL cover: ch0 = -128 with AXIS_BCD_SIGN_EN -> ch0 field 0x050, Sign_o[0] = 1; without the macro -> 0x000, Sign_o[0] = 0.
REQ-035 SHALL cover: ch1 = 2600 (10.156 units) -> ch1 field 0x999, Overflow_o[1] = 1; ch1 = -32768 with AXIS_BCD_SIGN_EN -> 0x999, Overflow_o[1] = 1, Sign_o[1] = 1.
REQ-036 SHALL cover: a second Data_Available_i and changed Data_i mid-conversion -> exactly one done pulse, with results from the first snapshot.
REQ-037 SHALL cover: Reset_i asserted mid-conversion for one cycle -> all outputs 0, no done pulse, and a following request converts correctly.
REQ-038 SHALL cover: CHANNELS=1, DATA_W=12, RESOLUTION=100, INT_DIGITS=2, FRAC_DIGITS=1, sample 1234 -> Data_o = 0x123.
